adder_share_ctrl: RTL and testbench

Sequencer and round-robin arbiter that shares one 32-bit `yAdder` instance (ports `z, cout, a, b, cin`) between two requesters. It accepts narrow 32-bit operations and wide 64-bit operations. A wide operation runs as two adder passes, low word then high word, with the carry chained through a register. The block sits between the two requesting units and the shared adder datapath, and returns each tagged result on a single valid/ready response port.

---
 rtl/adder_share_ctrl.sv | 156 +++++++++++++++
 tb/tb_adder_share_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
// Two-requester sequencer around one shared W-bit ripple adder.
// Wide operations take two adder passes (low word, then high word) with the carry held in a register.
module yAdder #(
  parameter int W = 32
) (
  output logic [W-1:0] z,
  output logic         cout,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin
);
  logic [W:0] c;

  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign z[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[W];
endmodule

module adder_share_ctrl #(
  parameter int   W          = 32,
  parameter logic PRIO_RESET = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic           req0_wide,
  input  logic [2*W-1:0] req0_a,
  input  logic [2*W-1:0] req0_b,
  input  logic           req0_cin,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic           req1_wide,
  input  logic [2*W-1:0] req1_a,
  input  logic [2*W-1:0] req1_b,
  input  logic           req1_cin,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_sum,
  output logic           rsp_cout,
  output logic           busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]     state;
  logic           rr;
  logic           op_wide;
  logic           op_id;
  logic           op_cin;
  logic [2*W-1:0] op_a;
  logic [2*W-1:0] op_b;
  logic [W-1:0]   sum_lo;
  logic [W-1:0]   sum_hi;
  logic           c_lo;
  logic           cout_r;

  logic           grant0;
  logic           grant1;
  logic           accept;
  logic           in_hi;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_z;
  logic           add_cin;
  logic           add_cout;

  // Grant depends only on state, valids and rr; gated by rst_n so readies read 0 during reset.
  always_comb begin
    grant0 = rst_n && (state == S_IDLE) && req0_valid && (!req1_valid || (rr == 1'b0));
    grant1 = rst_n && (state == S_IDLE) && req1_valid && (!req0_valid || (rr == 1'b1));
    accept = grant0 | grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    in_hi   = (state == S_HI);
    add_a   = in_hi ? op_a[2*W-1:W] : op_a[W-1:0];
    add_b   = in_hi ? op_b[2*W-1:W] : op_b[W-1:0];
    add_cin = in_hi ? c_lo : op_cin;
  end

  yAdder #(.W(W)) u_adder (
    .z    (add_z),
    .cout (add_cout),
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin)
  );

  // Operand capture is pure data and carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a   <= grant1 ? req1_a   : req0_a;
      op_b   <= grant1 ? req1_b   : req0_b;
      op_cin <= grant1 ? req1_cin : req0_cin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      rr      <= PRIO_RESET;
      op_wide <= 1'b0;
      op_id   <= 1'b0;
      sum_lo  <= '0;
      sum_hi  <= '0;
      c_lo    <= 1'b0;
      cout_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_wide <= grant1 ? req1_wide : req0_wide;
            op_id   <= grant1;
            rr      <= ~grant1;
            state   <= S_LO;
          end
        end
        S_LO: begin
          sum_lo <= add_z;
          c_lo   <= add_cout;
          if (op_wide) begin
            state <= S_HI;
          end else begin
            sum_hi <= '0;
            cout_r <= add_cout;
            state  <= S_RESP;
          end
        end
        S_HI: begin
          sum_hi <= add_z;
          cout_r <= add_cout;
          state  <= S_RESP;
        end
        default: begin
          if (rsp_ready) state <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign rsp_id    = op_id;
  assign rsp_sum   = {sum_hi, sum_lo};
  assign rsp_cout  = cout_r;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed and randomized checks of adder_share_ctrl: arbitration, latency, backpressure, reset.
module tb_adder_share_ctrl;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_wide, req0_cin;
  logic [63:0]   req0_a, req0_b;
  logic          req1_valid, req1_ready, req1_wide, req1_cin;
  logic [63:0]   req1_a, req1_b;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [63:0]   rsp_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  adder_share_ctrl #(.W(W), .PRIO_RESET(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_wide  (req0_wide),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_wide  (req1_wide),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic v, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic c);
    if (id == 1'b0) begin
      req0_valid = v; req0_wide = w; req0_a = a; req0_b = b; req0_cin = c;
    end else begin
      req1_valid = v; req1_wide = w; req1_a = a; req1_b = b; req1_cin = c;
    end
  endtask

  // One operation through the block; stall = cycles rsp_ready is held low in RESP.
  task automatic do_op(input logic id, input logic wide, input logic [63:0] a,
                       input logic [63:0] b, input logic cin, input int stall);
    logic [64:0] full;
    logic [63:0] es;
    logic        ec;
    int          n;
    if (wide) begin
      full = {1'b0, a} + {1'b0, b} + 65'(cin);
      es   = full[63:0];
      ec   = full[64];
    end else begin
      full = 65'(a[31:0]) + 65'(b[31:0]) + 65'(cin);
      es   = {32'h0, full[31:0]};
      ec   = full[32];
    end
    rsp_ready = (stall == 0);
    set_req(id, 1'b1, wide, a, b, cin);
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin tick(); n++; end
    chk("op_grant", id ? req1_ready : req0_ready, 1);
    chk("op_other_ready", id ? req0_ready : req1_ready, 0);
    @(posedge clk);
    #1;
    set_req(id, 1'b0, wide, a, b, cin);
    chk("op_ready_one_cycle", {req1_ready, req0_ready}, 0);
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("op_latency", n, wide ? 2 : 1);
    chk("op_sum", rsp_sum, es);
    chk("op_cout", rsp_cout, ec);
    chk("op_id", rsp_id, id);
    for (int s = 0; s < stall; s++) begin
      set_req(~id, 1'b1, 1'b0, 64'h5, 64'h6, 1'b0);
      tick();
      chk("bp_readies", {req1_ready, req0_ready}, 0);
      chk("bp_busy", busy, 1);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_sum", rsp_sum, es);
      chk("bp_cout", rsp_cout, ec);
      chk("bp_id", rsp_id, id);
    end
    set_req(~id, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    rsp_ready = 1'b1;
    tick();
    chk("op_busy_drop", busy, 0);
    chk("op_valid_drop", rsp_valid, 0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    set_req(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    #3;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_readies", {req1_ready, req0_ready}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Contention: both valid, alternating grants starting at requester 0.
    set_req(1'b0, 1'b1, 1'b0, 64'd5, 64'd7, 1'b0);
    set_req(1'b1, 1'b1, 1'b0, 64'd100, 64'd200, 1'b1);
    #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(req0_ready | req1_ready) && n < 20) begin tick(); n++; end
      chk("cont_both_ready", req0_ready & req1_ready, 0);
      chk("cont_order", req1_ready, i % 2);
      tick();
      n = 0;
      while (!rsp_valid && n < 20) begin tick(); n++; end
      chk("cont_id", rsp_id, i % 2);
      chk("cont_sum", rsp_sum, (i % 2) ? 64'd301 : 64'd12);
      tick();
    end
    set_req(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    set_req(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    tick();

    // Lone requester 1 twice, wide vectors.
    do_op(1'b1, 1'b1, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 0);
    do_op(1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 0);
    // Narrow vectors; upper operand bits must be ignored.
    do_op(1'b0, 1'b0, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 0);
    do_op(1'b0, 1'b0, 64'h12345678_80000000, 64'hABCD0000_80000000, 1'b1, 0);
    // Backpressure: 5 cycles with rsp_ready low.
    do_op(1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_7654_3211, 1'b0, 5);

    // Reset during HI; rr is 1 at that point, so the post-reset grant proves rr reload.
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 1'b1, 64'h1111_1111_2222_2222, 64'h1, 1'b0);
    #1;
    chk("mid_grant", req0_ready, 1);
    tick();
    set_req(1'b0, 1'b0, 1'b1, 64'h1111_1111_2222_2222, 64'h1, 1'b0);
    tick();
    chk("mid_in_hi_busy", busy, 1);
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 64'h3, 64'h4, 1'b0);
    set_req(1'b1, 1'b1, 1'b0, 64'h3, 64'h4, 1'b0);
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", rsp_sum, 0);
    chk("mid_rst_cout", rsp_cout, 0);
    chk("mid_rst_id", rsp_id, 0);
    chk("mid_rst_readies", {req1_ready, req0_ready}, 0);
    set_req(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    set_req(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_rsp", {busy, rsp_valid}, 0);
    end
    set_req(1'b0, 1'b1, 1'b0, 64'h3, 64'h4, 1'b0);
    set_req(1'b1, 1'b1, 1'b0, 64'h3, 64'h4, 1'b0);
    #1;
    chk("post_rst_first_grant", {req1_ready, req0_ready}, 2'b01);
    set_req(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    set_req(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0);
    tick();

    // Randomized operations against an a+b+cin golden model.
    for (int i = 0; i < 1000; i++) begin
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
